// File: rtl/pipelined_datapath.sv
// pipelined_datapath: two-stage register-file/ALU pipeline with valid/ready issue.
// FORWARDING_EN forwards the EX result to the issuing operation instead of stalling one cycle.
module pipelined_datapath #(
  parameter int ADDRESS_WIDTH      = 5,
  parameter int DATA_WIDTH         = 32,
  parameter int ALU_CONTROL_LENGTH = 3,
  parameter int A0_INDEX           = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDRESS_WIDTH-1:0]      AD1,
  input  logic [ADDRESS_WIDTH-1:0]      AD2,
  input  logic [ADDRESS_WIDTH-1:0]      AD3,
  input  logic                          WE3,
  input  logic                          ALUsrc,
  input  logic [DATA_WIDTH-1:0]         ImmOP,
  input  logic [ALU_CONTROL_LENGTH-1:0] ALUCtrl,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         result,
  output logic                          EQ,
  output logic [DATA_WIDTH-1:0]         a0
);
  localparam int SW = $clog2(DATA_WIDTH);
  localparam int NR = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] A0 = ADDRESS_WIDTH'(A0_INDEX);
  logic [DATA_WIDTH-1:0]         r_rf [NR];
  logic                          r_ex_valid;
  logic [DATA_WIDTH-1:0]         r_ex_op1;
  logic [DATA_WIDTH-1:0]         r_ex_op2;
  logic [ADDRESS_WIDTH-1:0]      r_ex_ad3;
  logic                          r_ex_we3;
  logic [ALU_CONTROL_LENGTH-1:0] r_ex_ctrl;
  logic                          r_out_valid;
  logic [DATA_WIDTH-1:0]         r_result;
  logic                          r_eq;
  logic [DATA_WIDTH-1:0]         w_alu;
  logic [DATA_WIDTH-1:0]         w_rd1;
  logic [DATA_WIDTH-1:0]         w_rd2;
  logic [DATA_WIDTH-1:0]         w_op1;
  logic [DATA_WIDTH-1:0]         w_op2;
  logic [SW-1:0]                 w_sh;
  logic                          w_slt;
  logic                          w_eq;
  logic                          w_ex_wr;
  logic                          w_haz1;
  logic                          w_haz2;
  logic                          w_fire;
  always_comb begin
    w_sh  = r_ex_op2[SW-1:0];
    w_slt = $signed(r_ex_op1) < $signed(r_ex_op2);
    w_eq  = r_ex_op1 == r_ex_op2;
    w_alu = r_ex_ctrl == ALU_CONTROL_LENGTH'(0) ? r_ex_op1 + r_ex_op2 :
            r_ex_ctrl == ALU_CONTROL_LENGTH'(1) ? r_ex_op1 - r_ex_op2 :
            r_ex_ctrl == ALU_CONTROL_LENGTH'(2) ? r_ex_op1 & r_ex_op2 :
            r_ex_ctrl == ALU_CONTROL_LENGTH'(3) ? r_ex_op1 | r_ex_op2 :
            r_ex_ctrl == ALU_CONTROL_LENGTH'(4) ? r_ex_op1 ^ r_ex_op2 :
            r_ex_ctrl == ALU_CONTROL_LENGTH'(5) ? r_ex_op1 << w_sh :
            r_ex_ctrl == ALU_CONTROL_LENGTH'(6) ? r_ex_op1 >> w_sh :
            r_ex_ctrl == ALU_CONTROL_LENGTH'(7) ? {{(DATA_WIDTH-1){1'b0}}, w_slt} : '0;
  end
  // register 0 is never written and never a forwarding source (w_ex_wr excludes it)
  always_comb begin
    w_rd1   = AD1 == '0 ? '0 : r_rf[AD1];
    w_rd2   = AD2 == '0 ? '0 : r_rf[AD2];
    w_ex_wr = r_ex_valid && r_ex_we3 && r_ex_ad3 != '0;
    w_haz1  = w_ex_wr && AD1 == r_ex_ad3;
    w_haz2  = w_ex_wr && !ALUsrc && AD2 == r_ex_ad3;
`ifdef FORWARDING_EN
    w_op1    = w_haz1 ? w_alu : w_rd1;
    w_op2    = ALUsrc ? ImmOP : w_haz2 ? w_alu : w_rd2;
    in_ready = !rst;
`else
    w_op1    = w_rd1;
    w_op2    = ALUsrc ? ImmOP : w_rd2;
    in_ready = !rst && !(w_haz1 || w_haz2);
`endif
    w_fire   = in_valid && in_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf        <= '{default: '0};
      r_ex_valid  <= 1'b0;
      r_ex_op1    <= '0;
      r_ex_op2    <= '0;
      r_ex_ad3    <= '0;
      r_ex_we3    <= 1'b0;
      r_ex_ctrl   <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_eq        <= 1'b0;
    end else begin
      r_ex_valid  <= w_fire;
      r_out_valid <= r_ex_valid;
      if (w_fire) begin
        r_ex_op1  <= w_op1;
        r_ex_op2  <= w_op2;
        r_ex_ad3  <= AD3;
        r_ex_we3  <= WE3;
        r_ex_ctrl <= ALUCtrl;
      end
      if (r_ex_valid) begin
        r_result <= w_alu;
        r_eq     <= w_eq;
      end
      if (w_ex_wr) r_rf[r_ex_ad3] <= w_alu;
    end
  end
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign EQ        = r_eq;
  assign a0        = r_rf[A0];
endmodule

// File: tb/tb_pipelined_datapath.sv
// tb_pipelined_datapath: directed vector table plus hand sequences for timing,
// hazards, register 0, a0 and mid-operation reset.
module tb_pipelined_datapath;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  AD1, AD2, AD3;
  logic        WE3, ALUsrc;
  logic [31:0] ImmOP;
  logic [2:0]  ALUCtrl;
  logic        out_valid;
  logic [31:0] result;
  logic        EQ;
  logic [31:0] a0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  ctrl;
    logic [4:0]  ad1, ad2, ad3;
    logic        we, src;
    logic [31:0] imm;
    logic [31:0] exp_res;
    logic        exp_eq;
  } vec_t;

  vec_t vecs[15];

  pipelined_datapath dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .ALUsrc(ALUsrc),
    .ImmOP(ImmOP), .ALUCtrl(ALUCtrl), .out_valid(out_valid),
    .result(result), .EQ(EQ), .a0(a0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_op(input vec_t v);
    ALUCtrl = v.ctrl; AD1 = v.ad1; AD2 = v.ad2; AD3 = v.ad3;
    WE3 = v.we; ALUsrc = v.src; ImmOP = v.imm;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // presents the current op and returns just after the edge that accepts it
  task automatic accept;
    int n;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 8) begin
      tick();
      n++;
    end
    chk("accept_ready", {31'b0, in_ready}, 32'd1);
    tick();
  endtask

  function automatic vec_t mk(input logic [2:0] c, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [4:0] a3, input logic we, input logic src,
                              input logic [31:0] imm, input logic [31:0] r, input logic e);
    vec_t v;
    v.ctrl = c; v.ad1 = a1; v.ad2 = a2; v.ad3 = a3; v.we = we; v.src = src;
    v.imm = imm; v.exp_res = r; v.exp_eq = e;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'hFFFFFFF0, 32'hFFFFFFF0, 1'b0);
    vecs[1]  = mk(3'd1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 32'd4, 32'hFFFFFFEC, 1'b0);
    vecs[2]  = mk(3'd2, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 32'd4, 32'h00000000, 1'b0);
    vecs[3]  = mk(3'd3, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 32'd4, 32'hFFFFFFF4, 1'b0);
    vecs[4]  = mk(3'd4, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 32'd4, 32'hFFFFFFF4, 1'b0);
    vecs[5]  = mk(3'd5, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 32'd4, 32'hFFFFFF00, 1'b0);
    vecs[6]  = mk(3'd6, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 32'd4, 32'h0FFFFFFF, 1'b0);
    vecs[7]  = mk(3'd7, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 32'd4, 32'h00000001, 1'b0);
    vecs[8]  = mk(3'd1, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0, 32'd0, 32'h00000000, 1'b1);
    vecs[9]  = mk(3'd7, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0, 32'd0, 32'h00000000, 1'b1);
    vecs[10] = mk(3'd0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 32'h10, 32'h00000000, 1'b0);
    vecs[11] = mk(3'd0, 5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 32'd5, 32'h00000005, 1'b0);
    vecs[12] = mk(3'd7, 5'd2, 5'd1, 5'd0, 1'b0, 1'b0, 32'd0, 32'h00000000, 1'b0);
    vecs[13] = mk(3'd5, 5'd2, 5'd0, 5'd0, 1'b0, 1'b1, 32'h24, 32'h00000050, 1'b0);
    vecs[14] = mk(3'd1, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0, 32'd0, 32'hFFFFFFFB, 1'b0);

    rst = 1'b1; in_valid = 1'b1;
    set_op(mk(3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'd5, 32'd0, 1'b0));
    tick(); tick();
    chk("ready_in_reset", {31'b0, in_ready}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_eq", {31'b0, EQ}, 32'd0);
    chk("rst_a0", a0, 32'd0);

    // addi x1=5: out_valid two cycles after accept, then result holds
    accept(); in_valid = 1'b0;
    chk("x1_5_not_yet", {31'b0, out_valid}, 32'd0);
    tick();
    chk("x1_5_valid", {31'b0, out_valid}, 32'd1);
    chk("x1_5_result", result, 32'd5);
    tick();
    chk("x1_5_valid_drop", {31'b0, out_valid}, 32'd0);
    chk("x1_5_hold", result, 32'd5);
    set_op(mk(3'd0, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0));
    accept(); in_valid = 1'b0; tick();
    chk("x1_read5", result, 32'd5);

    // back-to-back x1=7 then x2=x1+x1
    set_op(mk(3'd0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 32'd7, 32'd0, 1'b0));
    accept();
    set_op(mk(3'd0, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0));
    #1;
`ifdef FORWARDING_EN
    chk("haz_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_first", result, 32'd7);
    tick();
    chk("b2b_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_sum", result, 32'd14);
`else
    chk("haz_stall", {31'b0, in_ready}, 32'd0);
    tick();
    chk("b2b_first", result, 32'd7);
    chk("stall_release", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("stall_bubble", {31'b0, out_valid}, 32'd0);
    tick();
    chk("b2b_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b_sum", result, 32'd14);
`endif

    // write to x0 is discarded and never forwarded
    set_op(mk(3'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 32'd9, 32'd0, 1'b0));
    accept();
    set_op(mk(3'd0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0));
    #1;
    chk("x0_no_haz", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("x0_first", result, 32'd9);
    tick();
    chk("x0_reads_zero", result, 32'd0);

    // ALU sweep table
    for (int i = 0; i < 15; i++) begin
      set_op(vecs[i]);
      accept();
      in_valid = 1'b0;
      tick();
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      chk($sformatf("vec%0d_eq", i), {31'b0, EQ}, {31'b0, vecs[i].exp_eq});
    end

    // a0 updates in the retire cycle
    set_op(mk(3'd0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 32'h1234, 32'd0, 1'b0));
    accept(); in_valid = 1'b0;
    chk("a0_before", a0, 32'd0);
    tick();
    chk("a0_after", a0, 32'h1234);

    // reset while an op sits in EX drops it
    set_op(mk(3'd0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 32'h55, 32'd0, 1'b0));
    accept(); in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_a0", a0, 32'd0);
    tick();
    chk("mid_rst_no_retire", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_a0_later", a0, 32'd0);
    chk("mid_rst_result", result, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipelined_datapath.md
# pipelined_datapath

Two-stage pipelined successor to the single-cycle register-file/ALU datapath. It takes one register-register or register-immediate operation per cycle through a valid/ready handshake. It executes the operation on a widened eight-operation ALU and writes the result back to a parametrised register file. It sits between the instruction decoder and the register file consumers, and exposes the retired result, the equality flag and the a0 register.

## Interface

Parameters:
- ADDRESS_WIDTH, 5, register index width; the register file has 2**ADDRESS_WIDTH entries.
- DATA_WIDTH, 32, register/ALU data width; must be a power of two and at least 8.
- ALU_CONTROL_LENGTH, 3, ALUCtrl width; only the encodings listed below are defined.
- A0_INDEX, 10, register index driven on a0.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  an operation is presented on the input bus.
- in_ready  out  1  the datapath accepts the operation this cycle.
- AD1, AD2  in  ADDRESS_WIDTH  source register indices.
- AD3  in  ADDRESS_WIDTH  destination register index.
- WE3  in  1  write the result to AD3.
- ALUsrc  in  1  0: operand 2 is RD2; 1: operand 2 is ImmOP.
- ImmOP  in  DATA_WIDTH  immediate, already sign-extended upstream.
- ALUCtrl  in  ALU_CONTROL_LENGTH  operation select.
- out_valid  out  1  result/EQ hold a retired operation this cycle.
- result  out  DATA_WIDTH  retired ALU result.
- EQ  out  1  operand1 == operand2 for the retired operation.
- a0  out  DATA_WIDTH  current contents of register A0_INDEX.

## Operation

- Accept: an operation is accepted when in_valid && in_ready. The operands are read, with forwarding applied, and latched into the EX register together with AD3, WE3 and ALUCtrl. The EX valid bit is set.
- Register 0 reads as zero. Writes to register 0 are discarded, and register 0 is never a forwarding source.
- ALUCtrl encodings:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 xor
  - 101 shift left logical
  - 110 shift right logical
  - 111 set-less-than signed, result 1 or 0 zero-extended
- Shifts use the low $clog2(DATA_WIDTH) bits of operand 2.
- Add and sub wrap modulo 2**DATA_WIDTH; there is no carry or overflow output.
- EQ compares the full operand 1 and operand 2 (after the ALUsrc mux), independent of ALUCtrl.
- Retire: an EX stage holding a valid operation latches the ALU output into result, EQ into EQ, and sets out_valid for one cycle. On the same edge, if WE3 is set and AD3 != 0, it writes the register file. Cycles with no valid EX operation clear out_valid; result and EQ hold their last value.
- Hazard: the issuing operation reads AD1, or reads AD2 with ALUsrc=0, that equals the EX-stage AD3, while the EX stage is valid with WE3=1 and AD3 != 0. Handling depends on the configuration (see below).
- No hazard exists against the retire stage, because the register file is already updated when the next operation reads it.
- a0 is a continuous read of register A0_INDEX and reflects each write on the cycle after the write edge.

## Timing

- Accept in cycle N:
  - operands latched at the end of N;
  - ALU evaluates in N+1;
  - result, EQ and out_valid visible in N+2;
  - register file and a0 updated in N+2.
- Throughput is one operation per cycle with no hazard.
- in_ready is combinational. It is 0 while rst=1, and otherwise 1 except during a stall (non-forwarding build only).
- Reset values:
  - all register file entries 0;
  - EX valid 0;
  - out_valid 0;
  - result 0;
  - EQ 0;
  - a0 0.
- Reset mid-operation drops any EX-stage operation without writeback. An operation whose retire edge coincides with rst=1 does not write.
- Back-to-back writes to the same register: the later one wins, and each is visible to its direct successor.

## Configuration

- FORWARDING_EN defined: a hazard is resolved by forwarding the combinational EX-stage ALU output to the matching operand. in_ready never drops for hazards.
- FORWARDING_EN undefined: a hazard forces in_ready=0 for exactly one cycle. The EX operation retires during that cycle, and the held operation is accepted on the next cycle, reading the updated register file. The upstream holds its inputs stable while in_valid && !in_ready.

## Test plan

- Reset, then write x1=5 (addi, ALUsrc=1, ImmOP=5, AD3=1) -> out_valid pulses two cycles after accept, result=5. x1 reads 5 thereafter.
- Back-to-back x1=7 (addi), then x2=x1+x1 (AD1=AD2=1, ALUsrc=0) -> result 14.
  - FORWARDING_EN: the second op is accepted the cycle after the first.
  - Without FORWARDING_EN: in_ready=0 for one cycle, and the second op retires one cycle later.
- Write x0=9 with WE3=1, then add x3=x0+0 -> x3=0; no forwarding of 9.
- ALU sweep with x1=0xFFFFFFF0 and ImmOP=4:
  - sub gives 0xFFFFFFEC;
  - sll gives 0xFFFFFF00;
  - srl gives 0x0FFFFFFF;
  - slt gives 1;
  - EQ=0.
  - x1 compared with itself gives EQ=1.
- Write x10=0x1234 -> a0 becomes 0x1234 in the retire cycle. Assert rst while an op is in EX -> no write, out_valid=0, a0=0.
